// File: rtl/gpio_in_conditioner_pkg.sv
// rtl/gpio_in_conditioner_pkg.sv - shared types and default sizes for the GPIO input conditioner
// Purpose: package gpio_cond_pkg, which holds the per-channel debounce state encoding and
//          the default parameter values that the rest of the bundle reuses.
// Ports:   none (package).
package gpio_cond_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } db_state_e;

  localparam int NCH_DEF         = 32;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int PRESC_W_DEF     = 16;
  localparam int CNT_W_DEF       = 4;

endpackage

// File: rtl/gpio_in_conditioner_if.sv
// rtl/gpio_in_conditioner_if.sv - pad/config/output bundle of the GPIO input conditioner
// Purpose: groups the raw pad inputs, the debounce configuration and the conditioned outputs.
//          Macro GPIO_COND_IRQ_EN adds the edge-status and interrupt signals.
// Ports:   master = pad/config driver side, slave = conditioner side.
//          pad_i, db_en, tick_div, stable_ticks -> conditioner
//          in_o, rise_o, fall_o                 <- conditioner
//          irq_mask, sts_clr -> / edge_sts_o, irq_o <- (GPIO_COND_IRQ_EN only)
interface gpio_in_conditioner_if #(
  parameter int NCH     = 32,
  parameter int PRESC_W = 16,
  parameter int CNT_W   = 4
);
  logic [NCH-1:0]     pad_i;
  logic [NCH-1:0]     db_en;
  logic [PRESC_W-1:0] tick_div;
  logic [CNT_W-1:0]   stable_ticks;
  logic [NCH-1:0]     in_o;
  logic [NCH-1:0]     rise_o;
  logic [NCH-1:0]     fall_o;
`ifdef GPIO_COND_IRQ_EN
  logic [NCH-1:0]     irq_mask;
  logic [NCH-1:0]     sts_clr;
  logic [NCH-1:0]     edge_sts_o;
  logic               irq_o;

  modport master (
    output pad_i, db_en, tick_div, stable_ticks, irq_mask, sts_clr,
    input  in_o, rise_o, fall_o, edge_sts_o, irq_o
  );
  modport slave (
    input  pad_i, db_en, tick_div, stable_ticks, irq_mask, sts_clr,
    output in_o, rise_o, fall_o, edge_sts_o, irq_o
  );
`else
  modport master (
    output pad_i, db_en, tick_div, stable_ticks,
    input  in_o, rise_o, fall_o
  );
  modport slave (
    input  pad_i, db_en, tick_div, stable_ticks,
    output in_o, rise_o, fall_o
  );
`endif
endinterface

// File: rtl/gpio_db_chan.sv
// rtl/gpio_db_chan.sv - one conditioner channel: synchroniser, debounce FSM and edge pulses
// Purpose: synchronises one pad, optionally debounces it against the shared tick and
//          emits single-cycle rise/fall pulses registered together with the level.
// Ports:   clk, rst_n     clock, asynchronous active-low reset
//          pad            raw asynchronous pad input
//          db_en          1 = debounce, 0 = bypass (level follows synchronised input)
//          tick           shared prescaler tick
//          stable_ticks   ticks a new level must persist beyond the first
//          level          conditioned level
//          rise, fall     one-cycle pulses in the first cycle level shows a new value
module gpio_db_chan
  import gpio_cond_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 4,
  parameter logic RST_BIT     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pad,
  input  logic             db_en,
  input  logic             tick,
  input  logic [CNT_W-1:0] stable_ticks,
  output logic             level,
  output logic             rise,
  output logic             fall
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, fall_q;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{RST_BIT}};
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= RST_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pad};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      // Edge pulses share the register stage with the level so they line up exactly.
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    if (!db_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      level_d = s;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s != level_q) begin
            state_d = PEND;
            cnt_d   = '0;
          end
        end
        PEND: begin
          // A return to the committed level rejects the glitch even on a tick cycle.
          if (s == level_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (tick) begin
            // >= rather than == so a mid-pending decrease of stable_ticks still commits.
            if (cnt_q >= stable_ticks) begin
              level_d = s;
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// rtl/gpio_in_conditioner.sv - N-channel GPIO input synchroniser/debouncer with edge pulses
// Purpose: top level; holds the shared debounce prescaler, instantiates NCH channels and,
//          when macro GPIO_COND_IRQ_EN is defined, the sticky edge status and interrupt.
// Ports:   clk, rst_n  clock, asynchronous active-low reset
//          bus (slave) pad_i, db_en, tick_div, stable_ticks in; in_o, rise_o, fall_o out;
//                      with GPIO_COND_IRQ_EN also irq_mask, sts_clr in; edge_sts_o, irq_o out
module gpio_in_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int             NCH         = NCH_DEF,
  parameter int             SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int             PRESC_W     = PRESC_W_DEF,
  parameter int             CNT_W       = CNT_W_DEF,
  parameter logic [NCH-1:0] RST_VAL     = '0
) (
  input logic                  clk,
  input logic                  rst_n,
  gpio_in_conditioner_if.slave bus
);

  localparam logic [PRESC_W-1:0] PRESC_ONE = 1;

  logic [PRESC_W-1:0] presc_q;
  logic               tick;
  logic [NCH-1:0]     level_w, rise_w, fall_w;

  // Free-running prescaler; a terminal count lowered below the current count is only
  // reached again after the natural wrap, so no early tick is ever produced.
  assign tick = (presc_q == bus.tick_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRESC_ONE;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    gpio_db_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W),
      .RST_BIT    (RST_VAL[i])
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .pad         (bus.pad_i[i]),
      .db_en       (bus.db_en[i]),
      .tick        (tick),
      .stable_ticks(bus.stable_ticks),
      .level       (level_w[i]),
      .rise        (rise_w[i]),
      .fall        (fall_w[i])
    );
  end

  assign bus.in_o   = level_w;
  assign bus.rise_o = rise_w;
  assign bus.fall_o = fall_w;

`ifdef GPIO_COND_IRQ_EN
  logic [NCH-1:0] sts_q;
  logic           irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sts_q <= '0;
      irq_q <= 1'b0;
    end else begin
      // Set term is OR-ed in after the clear so a coincident new edge keeps the bit.
      sts_q <= (sts_q & ~bus.sts_clr) | ((rise_w | fall_w) & bus.irq_mask);
      irq_q <= |sts_q;
    end
  end

  assign bus.edge_sts_o = sts_q;
  assign bus.irq_o      = irq_q;
`endif

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb/tb_gpio_in_conditioner.sv - self-checking bench for gpio_in_conditioner (directed + random)
module tb_gpio_in_conditioner;

  localparam int NCH  = 8;
  localparam int SYNC = 2;
  localparam int PW   = 16;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpio_in_conditioner_if #(.NCH(NCH), .PRESC_W(PW), .CNT_W(CW)) bus ();

  gpio_in_conditioner #(
    .NCH(NCH), .SYNC_STAGES(SYNC), .PRESC_W(PW), .CNT_W(CW), .RST_VAL('0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pad history delay line, committed level, and number of ticks a
  // differing synchronised level has survived (-1 = nothing pending).
  logic [NCH-1:0] pad_hist[$];
  logic [NCH-1:0] m_lvl, m_rise, m_fall;
  int             m_wait[NCH];
  int             m_presc;
`ifdef GPIO_COND_IRQ_EN
  logic [NCH-1:0] m_sts;
  logic           m_irq;
`endif

  task automatic model_reset();
    pad_hist.delete();
    repeat (SYNC) pad_hist.push_back('0);
    m_lvl   = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_presc = 0;
    for (int c = 0; c < NCH; c++) m_wait[c] = -1;
`ifdef GPIO_COND_IRQ_EN
    m_sts = '0;
    m_irq = 1'b0;
`endif
  endtask

  task automatic model_step();
    logic [NCH-1:0] s, nl;
    logic           tick;
    tick = (m_presc == int'(bus.tick_div));
    s    = pad_hist[0];
    nl   = m_lvl;
    for (int c = 0; c < NCH; c++) begin
      if (!bus.db_en[c]) begin
        nl[c] = s[c];
        m_wait[c] = -1;
      end else if (s[c] == m_lvl[c]) begin
        m_wait[c] = -1;
      end else if (m_wait[c] < 0) begin
        m_wait[c] = 0;
      end else if (tick) begin
        if (m_wait[c] >= int'(bus.stable_ticks)) begin
          nl[c] = s[c];
          m_wait[c] = -1;
        end else begin
          m_wait[c]++;
        end
      end
    end
`ifdef GPIO_COND_IRQ_EN
    m_irq = |m_sts;
    m_sts = (m_sts & ~bus.sts_clr) | ((m_rise | m_fall) & bus.irq_mask);
`endif
    m_rise  = nl & ~m_lvl;
    m_fall  = ~nl & m_lvl;
    m_lvl   = nl;
    m_presc = tick ? 0 : (m_presc + 1) % (1 << PW);
    void'(pad_hist.pop_front());
    pad_hist.push_back(bus.pad_i);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_eq("in_o", bus.in_o, m_lvl);
    check_eq("rise_o", bus.rise_o, m_rise);
    check_eq("fall_o", bus.fall_o, m_fall);
`ifdef GPIO_COND_IRQ_EN
    check_eq("edge_sts_o", bus.edge_sts_o, m_sts);
    check_eq("irq_o", bus.irq_o, m_irq);
`endif
  endtask

  task automatic set_div(input int v);
    int g;
    for (g = 0; g < 100 && m_presc > v; g++) cycle();
    if (g == 100) check_eq("set_div_timeout", 1, 0);
    bus.tick_div = PW'(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen_hi, nrise, nf, g;
    bus.pad_i        = 8'hFF;
    bus.db_en        = 8'h00;
    bus.tick_div     = 16'd3;
    bus.stable_ticks = 4'd2;
`ifdef GPIO_COND_IRQ_EN
    bus.irq_mask = '0;
    bus.sts_clr  = '0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_in_o", bus.in_o, 8'h00);
    check_eq("reset_rise_o", bus.rise_o, 8'h00);
    rst_n = 1'b1;

    // Reset release with pads high in bypass: level appears on the third edge.
    cycle(); check_eq("rel_c1_in", bus.in_o, 8'h00);
    cycle(); check_eq("rel_c2_in", bus.in_o, 8'h00);
    cycle(); check_eq("rel_c3_in", bus.in_o, 8'hFF);
    check_eq("rel_c3_rise", bus.rise_o, 8'hFF);
    cycle(); check_eq("rel_c4_rise", bus.rise_o, 8'h00);

    // Bypass latency and single fall pulse on channel 3.
    bus.pad_i = 8'hF7;
    repeat (5) cycle();
    bus.pad_i = 8'hFF;
    cycle(); cycle();
    check_eq("byp_c2_in3", bus.in_o[3], 1'b0);
    cycle();
    check_eq("byp_c3_in3", bus.in_o[3], 1'b1);
    check_eq("byp_c3_rise3", bus.rise_o[3], 1'b1);
    bus.pad_i = 8'hF7;
    nf = 0;
    repeat (6) begin cycle(); nf += int'(bus.fall_o[3]); end
    check_eq("byp_fall3_pulses", nf, 1);

    // Glitch rejection: 6 high cycles cannot survive 3 ticks at period 4.
    bus.pad_i = 8'h00;
    repeat (6) cycle();
    bus.db_en = 8'h01;
    set_div(3);
    bus.stable_ticks = 4'd2;
    bus.pad_i[0] = 1'b1;
    seen_hi = 0; nrise = 0;
    repeat (6) begin cycle(); seen_hi |= int'(bus.in_o[0]); nrise += int'(bus.rise_o[0]); end
    bus.pad_i[0] = 1'b0;
    repeat (20) begin cycle(); seen_hi |= int'(bus.in_o[0]); nrise += int'(bus.rise_o[0]); end
    check_eq("glitch_in0", seen_hi, 0);
    check_eq("glitch_rise0", nrise, 0);

    // Stable commit: 2 sync + 1 PEND entry + 3 ticks of period 4 -> 12..15 cycles.
    bus.pad_i[0] = 1'b1;
    lat = 0;
    for (g = 1; g <= 40 && lat == 0; g++) begin
      cycle();
      if (bus.in_o[0]) begin
        lat = g;
        check_eq("commit_rise0", bus.rise_o[0], 1'b1);
      end
    end
    check_eq("commit_window", (lat >= 12 && lat <= 15), 1);

    // tick every cycle, stable_ticks 0: commit one cycle after PEND entry.
    set_div(0);
    bus.stable_ticks = 4'd0;
    repeat (3) cycle();
    bus.pad_i[0] = 1'b0;
    lat = 0;
    for (g = 1; g <= 20 && lat == 0; g++) begin
      cycle();
      if (!bus.in_o[0]) lat = g;
    end
    check_eq("fast_commit_lat", lat, 4);

    // db_en dropped after one tick in PEND: level follows s next cycle.
    set_div(3);
    bus.stable_ticks = 4'd2;
    bus.pad_i[0] = 1'b1;
    for (g = 0; g < 40 && m_wait[0] != 1; g++) cycle();
    check_eq("pend_reach_1", m_wait[0], 1);
    bus.db_en[0] = 1'b0;
    cycle();
    check_eq("dben_drop_in0", bus.in_o[0], 1'b1);
    bus.db_en[0] = 1'b1;
    repeat (3) cycle();
    check_eq("dben_rearm_in0", bus.in_o[0], 1'b1);

    // stable_ticks lowered 5 -> 1 with three ticks survived: commit on the next tick.
    bus.stable_ticks = 4'd5;
    bus.pad_i[0] = 1'b0;
    for (g = 0; g < 60 && m_wait[0] != 3; g++) cycle();
    check_eq("pend_reach_3", m_wait[0], 3);
    bus.stable_ticks = 4'd1;
    lat = 0;
    for (g = 1; g <= 10 && lat == 0; g++) begin
      cycle();
      if (!bus.in_o[0]) lat = g;
    end
    check_eq("lower_st_commit", (lat >= 1 && lat <= 4), 1);

`ifdef GPIO_COND_IRQ_EN
    bus.irq_mask = 8'h01;
    bus.stable_ticks = 4'd0;
    bus.pad_i[0] = 1'b1;
    for (g = 0; g < 40 && !bus.rise_o[0]; g++) cycle();
    check_eq("irq_rise_seen", bus.rise_o[0], 1'b1);
    cycle();
    check_eq("irq_sts0_set", bus.edge_sts_o[0], 1'b1);
    cycle();
    check_eq("irq_o_set", bus.irq_o, 1'b1);
    bus.sts_clr = 8'h01;
    cycle();
    bus.sts_clr = 8'h00;
    check_eq("irq_sts0_clr", bus.edge_sts_o[0], 1'b0);
    bus.pad_i[0] = 1'b0;
    for (g = 0; g < 40 && !m_fall[0]; g++) cycle();
    check_eq("irq_fall_seen", bus.fall_o[0], 1'b1);
    bus.sts_clr = 8'h01;
    cycle();
    bus.sts_clr = 8'h00;
    check_eq("irq_set_wins", bus.edge_sts_o[0], 1'b1);
    bus.sts_clr = 8'hFF;
    cycle();
    bus.sts_clr = 8'h00;
    bus.pad_i[1] = ~bus.pad_i[1];
    repeat (6) cycle();
    check_eq("irq_unmasked_ch1", bus.edge_sts_o[1], 1'b0);
`endif

    // Randomised run: sparse pad flips, occasional config changes.
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 7) == 0) bus.pad_i[c] = ~bus.pad_i[c];
      if ($urandom_range(0, 49) == 0) bus.db_en = NCH'($urandom);
      if ($urandom_range(0, 29) == 0) bus.stable_ticks = CW'($urandom_range(0, 3));
      if (m_presc == 0 && $urandom_range(0, 39) == 0) bus.tick_div = PW'($urandom_range(0, 3));
`ifdef GPIO_COND_IRQ_EN
      if ($urandom_range(0, 49) == 0) bus.irq_mask = NCH'($urandom);
      bus.sts_clr = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : '0;
`endif
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
